// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the ram64 DMA copy engine.
// Optional feature macro used by the top: RAM_DMA_FILL_EN.
package ram_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 7;

  localparam logic [LEN_W-1:0] MAX_LEN = 7'd64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } dma_state_t;

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Source/destination pointers and remaining-word counter for ram_dma_copy.
// A load takes priority over a step; the pointers wrap silently modulo 2**ADDR_W.
module ram_dma_addr_gen
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [LEN_W-1:0]  remaining
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      rem_d = len_in;
    end else if (step) begin
      src_d = src_q + ADDR_W'(1);
      dst_d = dst_q + ADDR_W'(1);
      rem_d = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src_ptr   = src_q;
  assign dst_ptr   = dst_q;
  assign remaining = rem_q;

endmodule

// File: rtl/ram_dma_copy.sv
// Block-copy bus master for the ram64 word RAM: copies len words from src to dst, 2 cycles/word.
// Define RAM_DMA_FILL_EN to add a fill mode (fill_en/fill_val) that writes a constant at 1 cycle/word.
module ram_dma_copy
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
`ifdef RAM_DMA_FILL_EN
  input  logic              fill_en,
  input  logic [DATA_W-1:0] fill_val,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  dma_state_t        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gen_load, gen_step;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_sat;
  logic              start_fill;
  logic              cur_fill;
  logic [DATA_W-1:0] write_val;

`ifdef RAM_DMA_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;

  always_comb begin
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    if (state_q == IDLE && start) begin
      fill_d     = fill_en;
      fill_val_d = fill_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else begin
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end

  assign start_fill = fill_en;
  assign cur_fill   = fill_q;
  assign write_val  = fill_q ? fill_val_q : hold_q;
`else
  assign start_fill = 1'b0;
  assign cur_fill   = 1'b0;
  assign write_val  = hold_q;
`endif

  assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;

  ram_dma_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (gen_load),
    .step      (gen_step),
    .src_in    (src),
    .dst_in    (dst),
    .len_in    (len_sat),
    .src_ptr   (src_ptr),
    .dst_ptr   (dst_ptr),
    .remaining (remaining)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          gen_load = 1'b1;
          if (len_sat == '0)   state_d = DONE;
          else if (start_fill) state_d = WRITE;
          else                 state_d = READ;
        end
      end
      READ: begin
        hold_d  = ram_out;
        state_d = WRITE;
      end
      WRITE: begin
        gen_step = 1'b1;
        if (remaining == LEN_W'(1)) state_d = DONE;
        else if (cur_fill)          state_d = WRITE;
        else                        state_d = READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == READ) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // RAM port is a pure decode of the state register, so reset drops ram_load at once.
  always_comb begin
    ram_adr  = '0;
    ram_data = '0;
    ram_load = 1'b0;
    case (state_q)
      READ:  ram_adr = src_ptr;
      WRITE: begin
        ram_adr  = dst_ptr;
        ram_data = write_val;
        ram_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
